// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage
//
// ID/EX pipeline register in front of the 32-bit ALU. It captures the decoded
// instruction from ID and resolves operand forwarding from EX/MEM and MEM/WB.
// It drives the ALU operands and opcode directly. It also raises a
// combinational load-use stall request and inserts a bubble when one is seen.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   id_*                       decoded instruction presented by decode
//   stall, flush               pipeline control (flush has priority)
//   mem_reg_write/rd/result    EX/MEM forwarding source
//   wb_reg_write/rd/result     MEM/WB forwarding source
//   ex_valid                   stage holds a live instruction
//   operand_a/b, alu_control   ALU inputs
//   ex_pc, ex_rd               registered PC and destination
//   ex_store_data              forwarded rs2 value (store data)
//   ex_reg_write/mem_read/mem_write  control bits gated by ex_valid
//   load_use_hazard            stall request to fetch/decode
// ---------------------------------------------------------------------------
module id_ex_stage #(
  parameter int XLEN = 32,
  parameter int RA_W = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            id_valid,
  input  logic [XLEN-1:0] id_pc,
  input  logic [RA_W-1:0] id_rs1,
  input  logic [RA_W-1:0] id_rs2,
  input  logic [RA_W-1:0] id_rd,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [XLEN-1:0] id_imm,
  input  logic [3:0]      id_alu_control,
  input  logic            id_alu_src_pc,
  input  logic            id_alu_src_imm,
  input  logic            id_reg_write,
  input  logic            id_mem_read,
  input  logic            id_mem_write,
  input  logic            stall,
  input  logic            flush,
  input  logic            mem_reg_write,
  input  logic [RA_W-1:0] mem_rd,
  input  logic [XLEN-1:0] mem_result,
  input  logic            wb_reg_write,
  input  logic [RA_W-1:0] wb_rd,
  input  logic [XLEN-1:0] wb_result,
  output logic            ex_valid,
  output logic [XLEN-1:0] operand_a,
  output logic [XLEN-1:0] operand_b,
  output logic [3:0]      alu_control,
  output logic [XLEN-1:0] ex_pc,
  output logic [RA_W-1:0] ex_rd,
  output logic [XLEN-1:0] ex_store_data,
  output logic            ex_reg_write,
  output logic            ex_mem_read,
  output logic            ex_mem_write,
  output logic            load_use_hazard
);

  logic            valid_q, valid_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [RA_W-1:0] rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
  logic [XLEN-1:0] rs1_data_q, rs1_data_d, rs2_data_q, rs2_data_d;
  logic [XLEN-1:0] imm_q, imm_d;
  logic [3:0]      alu_control_q, alu_control_d;
  logic            src_pc_q, src_pc_d, src_imm_q, src_imm_d;
  logic            reg_write_q, reg_write_d;
  logic            mem_read_q, mem_read_d;
  logic            mem_write_q, mem_write_d;
  logic [XLEN-1:0] fwd_rs1, fwd_rs2;

  // A writer hits a source register only if it writes, matches, and the
  // register is not x0.
  function automatic logic src_hit(input logic we, input logic [RA_W-1:0] wrd,
                                   input logic [RA_W-1:0] rs);
    return we && (wrd == rs) && (rs != '0);
  endfunction

  // The youngest producer (EX/MEM) wins over MEM/WB, which wins over the
  // value captured in this stage.
  function automatic logic [XLEN-1:0] fwd_sel(
    input logic [RA_W-1:0] rs, input logic [XLEN-1:0] reg_data,
    input logic m_we, input logic [RA_W-1:0] m_rd, input logic [XLEN-1:0] m_res,
    input logic w_we, input logic [RA_W-1:0] w_rd, input logic [XLEN-1:0] w_res);
    if (src_hit(m_we, m_rd, rs))      return m_res;
    else if (src_hit(w_we, w_rd, rs)) return w_res;
    else                              return reg_data;
  endfunction

  always_comb begin
    load_use_hazard = valid_q && mem_read_q && (rd_q != '0) && id_valid &&
                      ((rd_q == id_rs1) || (rd_q == id_rs2));
  end

  always_comb begin
    valid_d       = valid_q;
    pc_d          = pc_q;
    rs1_d         = rs1_q;
    rs2_d         = rs2_q;
    rd_d          = rd_q;
    rs1_data_d    = rs1_data_q;
    rs2_data_d    = rs2_data_q;
    imm_d         = imm_q;
    alu_control_d = alu_control_q;
    src_pc_d      = src_pc_q;
    src_imm_d     = src_imm_q;
    reg_write_d   = reg_write_q;
    mem_read_d    = mem_read_q;
    mem_write_d   = mem_write_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (stall) begin
      // A held instruction must not lose a write-back that retires while it
      // waits; once WB moves on, nothing else could supply that value.
      if (src_hit(wb_reg_write, wb_rd, rs1_q)) rs1_data_d = wb_result;
      if (src_hit(wb_reg_write, wb_rd, rs2_q)) rs2_data_d = wb_result;
    end else if (load_use_hazard) begin
      valid_d = 1'b0;
    end else begin
      valid_d       = id_valid;
      pc_d          = id_pc;
      rs1_d         = id_rs1;
      rs2_d         = id_rs2;
      rd_d          = id_rd;
      // The register file is read before WB writes it, so take WB directly.
      rs1_data_d    = src_hit(wb_reg_write, wb_rd, id_rs1) ? wb_result : id_rs1_data;
      rs2_data_d    = src_hit(wb_reg_write, wb_rd, id_rs2) ? wb_result : id_rs2_data;
      imm_d         = id_imm;
      alu_control_d = id_alu_control;
      src_pc_d      = id_alu_src_pc;
      src_imm_d     = id_alu_src_imm;
      reg_write_d   = id_reg_write;
      mem_read_d    = id_mem_read;
      mem_write_d   = id_mem_write;
    end
  end

  // ---- ID -> EX register boundary ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q       <= 1'b0;
      pc_q          <= '0;
      rs1_q         <= '0;
      rs2_q         <= '0;
      rd_q          <= '0;
      rs1_data_q    <= '0;
      rs2_data_q    <= '0;
      imm_q         <= '0;
      alu_control_q <= '0;
      src_pc_q      <= 1'b0;
      src_imm_q     <= 1'b0;
      reg_write_q   <= 1'b0;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
    end else begin
      valid_q       <= valid_d;
      pc_q          <= pc_d;
      rs1_q         <= rs1_d;
      rs2_q         <= rs2_d;
      rd_q          <= rd_d;
      rs1_data_q    <= rs1_data_d;
      rs2_data_q    <= rs2_data_d;
      imm_q         <= imm_d;
      alu_control_q <= alu_control_d;
      src_pc_q      <= src_pc_d;
      src_imm_q     <= src_imm_d;
      reg_write_q   <= reg_write_d;
      mem_read_q    <= mem_read_d;
      mem_write_q   <= mem_write_d;
    end
  end

  always_comb begin
    fwd_rs1 = fwd_sel(rs1_q, rs1_data_q, mem_reg_write, mem_rd, mem_result,
                      wb_reg_write, wb_rd, wb_result);
    fwd_rs2 = fwd_sel(rs2_q, rs2_data_q, mem_reg_write, mem_rd, mem_result,
                      wb_reg_write, wb_rd, wb_result);
  end

  assign ex_valid      = valid_q;
  assign operand_a     = src_pc_q  ? pc_q  : fwd_rs1;
  assign operand_b     = src_imm_q ? imm_q : fwd_rs2;
  assign alu_control   = alu_control_q;
  assign ex_pc         = pc_q;
  assign ex_rd         = rd_q;
  assign ex_store_data = fwd_rs2;
  assign ex_reg_write  = reg_write_q & valid_q;
  assign ex_mem_read   = mem_read_q  & valid_q;
  assign ex_mem_write  = mem_write_q & valid_q;

endmodule
